// File: rtl/cart_arbiter.sv
`timescale 1ns/1ps
// cart_arbiter: shares one cartridge memory port between the CPU and PPU.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
// PPU has priority. The CPU is guaranteed a slot after MAX_BURST back-to-back
// PPU grants made while it was waiting.
//
// state | meaning
// IDLE  | no transaction; arbitrate when cart_ready
// ISSUE | address/selects valid, one-cycle rden/wren strobe
// WAIT  | read latency countdown, address/selects held
// DONE  | one-cycle ack to the owner, read data already captured
module cart_arbiter #(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cart_ready,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic        cpu_ram_sel,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_req,
  input  logic        ppu_wr,
  input  logic [20:0] ppu_addr,
  input  logic [7:0]  ppu_wdata,
  output logic        ppu_ack,
  output logic [7:0]  ppu_rdata,
  output logic [20:0] mem_address,
  output logic        mem_prg_sel,
  output logic        mem_chr_sel,
  output logic        mem_ram_sel,
  output logic        mem_rden,
  output logic        mem_wren,
  output logic [7:0]  mem_write_data,
  input  logic [7:0]  mem_read_data
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  // WAIT lasts READ_LAT-1 cycles; the counter is loaded with the remaining
  // count after the first WAIT cycle and finishes on terminal count zero.
  localparam logic [2:0] WAIT_LOAD = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;
  localparam bit         NO_WAIT   = (READ_LAT <= 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [3:0]  burst_cnt_q;
  logic [3:0]  burst_cnt_d;
  logic [2:0]  wait_cnt_q;
  logic        owner_cpu_q;
  logic        wr_q;
  logic [20:0] mem_address_q;
  logic        mem_prg_sel_q;
  logic        mem_chr_sel_q;
  logic        mem_ram_sel_q;
  logic        mem_rden_q;
  logic        mem_wren_q;
  logic [7:0]  mem_write_data_q;
  logic        cpu_ack_q;
  logic        ppu_ack_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  ppu_rdata_q;

  logic        grant_d;
  logic        pick_cpu_d;
  logic        finish_d;

  // Arbitration decision, next burst count and end-of-access detection.
  always_comb begin
    grant_d    = cart_ready && (cpu_req || ppu_req);
    pick_cpu_d = cpu_req && (!ppu_req || (burst_cnt_q == BURST_MAX));
    if (pick_cpu_d || !cpu_req) begin
      burst_cnt_d = 4'd0;
    end else if (burst_cnt_q < BURST_MAX) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
    finish_d = ((state_q == ISSUE) && (wr_q || NO_WAIT)) ||
               ((state_q == WAIT) && (wait_cnt_q == 3'd0));
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      burst_cnt_q      <= 4'd0;
      wait_cnt_q       <= 3'd0;
      owner_cpu_q      <= 1'b0;
      wr_q             <= 1'b0;
      mem_address_q    <= 21'd0;
      mem_prg_sel_q    <= 1'b0;
      mem_chr_sel_q    <= 1'b0;
      mem_ram_sel_q    <= 1'b0;
      mem_rden_q       <= 1'b0;
      mem_wren_q       <= 1'b0;
      mem_write_data_q <= 8'd0;
      cpu_ack_q        <= 1'b0;
      ppu_ack_q        <= 1'b0;
      cpu_rdata_q      <= 8'd0;
      ppu_rdata_q      <= 8'd0;
    end else begin
      cpu_ack_q  <= 1'b0;
      ppu_ack_q  <= 1'b0;
      mem_rden_q <= 1'b0;
      mem_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= ISSUE;
            owner_cpu_q <= pick_cpu_d;
            burst_cnt_q <= burst_cnt_d;
            if (pick_cpu_d) begin
              wr_q             <= cpu_wr;
              mem_rden_q       <= !cpu_wr;
              mem_wren_q       <= cpu_wr;
              mem_address_q    <= cpu_addr;
              mem_write_data_q <= cpu_wdata;
              mem_prg_sel_q    <= !cpu_ram_sel;
              mem_ram_sel_q    <= cpu_ram_sel;
              mem_chr_sel_q    <= 1'b0;
            end else begin
              wr_q             <= ppu_wr;
              mem_rden_q       <= !ppu_wr;
              mem_wren_q       <= ppu_wr;
              mem_address_q    <= ppu_addr;
              mem_write_data_q <= ppu_wdata;
              mem_prg_sel_q    <= 1'b0;
              mem_ram_sel_q    <= 1'b0;
              mem_chr_sel_q    <= 1'b1;
            end
          end
        end
        ISSUE, WAIT: begin
          if (finish_d) begin
            state_q          <= DONE;
            cpu_ack_q        <= owner_cpu_q;
            ppu_ack_q        <= !owner_cpu_q;
            mem_address_q    <= 21'd0;
            mem_prg_sel_q    <= 1'b0;
            mem_chr_sel_q    <= 1'b0;
            mem_ram_sel_q    <= 1'b0;
            mem_write_data_q <= 8'd0;
            if (!wr_q) begin
              if (owner_cpu_q) begin
                cpu_rdata_q <= mem_read_data;
              end else begin
                ppu_rdata_q <= mem_read_data;
              end
            end
          end else if (state_q == ISSUE) begin
            state_q    <= WAIT;
            wait_cnt_q <= WAIT_LOAD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_prg_sel    = mem_prg_sel_q;
  assign mem_chr_sel    = mem_chr_sel_q;
  assign mem_ram_sel    = mem_ram_sel_q;
  assign mem_rden       = mem_rden_q;
  assign mem_wren       = mem_wren_q;
  assign mem_write_data = mem_write_data_q;
  assign cpu_ack        = cpu_ack_q;
  assign ppu_ack        = ppu_ack_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign ppu_rdata      = ppu_rdata_q;

endmodule

// File: tb/tb_cart_arbiter.sv
`timescale 1ns/1ps
// Bench for cart_arbiter: transaction-level reference model (grant cycle plus
// fixed latencies) compared against the DUT every cycle, with directed
// scenarios followed by randomized CPU/PPU traffic.
module tb_cart_arbiter;

  localparam int READ_LAT  = 2;
  localparam int MAX_BURST = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cart_ready = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_ram_sel = 1'b0;
  logic [20:0] cpu_addr = 21'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ppu_req = 1'b0;
  logic        ppu_wr = 1'b0;
  logic [20:0] ppu_addr = 21'd0;
  logic [7:0]  ppu_wdata = 8'd0;
  logic        ppu_ack;
  logic [7:0]  ppu_rdata;
  logic [20:0] mem_address;
  logic        mem_prg_sel;
  logic        mem_chr_sel;
  logic        mem_ram_sel;
  logic        mem_rden;
  logic        mem_wren;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data = 8'd0;

  cart_arbiter #(.READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset_n(reset_n), .cart_ready(cart_ready),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_ram_sel(cpu_ram_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .ppu_req(ppu_req), .ppu_wr(ppu_wr),
    .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_ack(ppu_ack),
    .ppu_rdata(ppu_rdata), .mem_address(mem_address),
    .mem_prg_sel(mem_prg_sel), .mem_chr_sel(mem_chr_sel),
    .mem_ram_sel(mem_ram_sel), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding transaction described by its
  // grant cycle g and completion cycle done_c.
  int          cyc = 0;
  bit          have = 1'b0;
  int          g = 0;
  int          done_c = 0;
  bit          m_cpu = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_take = 1'b0;
  logic [20:0] m_addr = 21'd0;
  logic [7:0]  m_wdata = 8'd0;
  logic [7:0]  m_rval = 8'd0;
  logic [2:0]  m_sel = 3'd0;
  logic [7:0]  e_cpu_rdata = 8'd0;
  logic [7:0]  e_ppu_rdata = 8'd0;
  int          streak = 0;
  bit          force_en = 1'b0;
  logic [7:0]  force_val = 8'd0;

  bit obs[$];
  int strobe_cnt = 0;
  int ack_cnt = 0;
  bit auto_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model update at each active edge using the inputs the DUT also sees.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      have        = 1'b0;
      streak      = 0;
      e_cpu_rdata = 8'd0;
      e_ppu_rdata = 8'd0;
    end else begin
      if (have && !m_wr && (cyc + 1 == done_c)) begin
        if (m_cpu) e_cpu_rdata = m_rval;
        else       e_ppu_rdata = m_rval;
      end
      if ((!have || cyc > done_c) && cart_ready && (cpu_req || ppu_req)) begin
        m_take = cpu_req && (!ppu_req || streak == MAX_BURST);
        have   = 1'b1;
        g      = cyc;
        m_cpu  = m_take;
        if (m_take) begin
          m_wr    = cpu_wr;
          m_addr  = cpu_addr;
          m_wdata = cpu_wdata;
          m_sel   = {!cpu_ram_sel, 1'b0, cpu_ram_sel};
          streak  = 0;
        end else begin
          m_wr    = ppu_wr;
          m_addr  = ppu_addr;
          m_wdata = ppu_wdata;
          m_sel   = 3'b010;
          streak  = cpu_req ? ((streak < MAX_BURST) ? streak + 1 : streak) : 0;
        end
        done_c = g + (m_wr ? 2 : READ_LAT + 1);
        m_rval = force_en ? force_val : 8'($urandom);
      end
      cyc++;
    end
  end

  task automatic agents(input bit ack_c, input bit ack_p);
    if (ack_c) cpu_req = 1'b0;
    else if (!cpu_req && $urandom_range(0, 2) == 0) begin
      cpu_req     = 1'b1;
      cpu_wr      = 1'($urandom_range(0, 1));
      cpu_ram_sel = 1'($urandom_range(0, 1));
      cpu_addr    = 21'($urandom);
      cpu_wdata   = 8'($urandom);
    end
    if (ack_p) ppu_req = 1'b0;
    else if (!ppu_req && $urandom_range(0, 2) == 0) begin
      ppu_req   = 1'b1;
      ppu_wr    = 1'($urandom_range(0, 1));
      ppu_addr  = 21'($urandom);
      ppu_wdata = 8'($urandom);
    end
    if ($urandom_range(0, 39) == 0) cart_ready = !cart_ready;
  endtask

  // One cycle: compare DUT outputs with the model, then drive stimulus.
  task automatic tick();
    bit iss, win, ackt;
    @(negedge clock);
    iss  = have && (cyc == g + 1);
    win  = have && (cyc >= g + 1) && (cyc < done_c);
    ackt = have && (cyc == done_c);
    check("ack", 32'({cpu_ack, ppu_ack}), ackt ? (m_cpu ? 32'd2 : 32'd1) : 32'd0);
    check("strobe", 32'({mem_rden, mem_wren}), iss ? (m_wr ? 32'd1 : 32'd2) : 32'd0);
    check("sel", 32'({mem_prg_sel, mem_chr_sel, mem_ram_sel}), win ? 32'(m_sel) : 32'd0);
    if (win) check("addr", 32'(mem_address), 32'(m_addr));
    if (iss && m_wr) check("wdata", 32'(mem_write_data), 32'(m_wdata));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    check("ppu_rdata", 32'(ppu_rdata), 32'(e_ppu_rdata));
    if (mem_rden || mem_wren) strobe_cnt++;
    if (cpu_ack || ppu_ack) begin
      ack_cnt++;
      obs.push_back(cpu_ack);
    end
    if (auto_en) agents(ackt && m_cpu, ackt && !m_cpu);
    if (have && !m_wr && (cyc == done_c - 1)) mem_read_data = m_rval;
    else mem_read_data = ~m_rval;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_ctl"}, 32'({mem_prg_sel, mem_chr_sel, mem_ram_sel, mem_rden,
                              mem_wren, cpu_ack, ppu_ack}), 32'd0);
    check({tag, "_wdata"}, 32'(mem_write_data), 32'd0);
    check({tag, "_rdata"}, 32'({cpu_rdata, ppu_rdata}), 32'd0);
  endtask

  task automatic do_req(input bit is_cpu, input bit wr, input bit ram,
                        input logic [20:0] a, input logic [7:0] d, input string tag);
    bit seen = 1'b0;
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_wr = wr; cpu_ram_sel = ram; cpu_addr = a; cpu_wdata = d;
    end else begin
      ppu_req = 1'b1; ppu_wr = wr; ppu_addr = a; ppu_wdata = d;
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (is_cpu ? cpu_ack : ppu_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (is_cpu) cpu_req = 1'b0;
    else ppu_req = 1'b0;
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    cart_ready = 1'b1;

    // CPU PRG read returning A5
    force_en = 1'b1; force_val = 8'hA5;
    do_req(1'b1, 1'b0, 1'b0, 21'h00123, 8'h00, "req021_ack");
    force_en = 1'b0;
    tick();
    check("req021_rdata", 32'(cpu_rdata), 32'hA5);

    // PPU CHR write
    strobe_cnt = 0;
    do_req(1'b0, 1'b1, 1'b0, 21'h01FFF, 8'h3C, "req022_ack");
    check("req022_strobes", 32'(strobe_cnt), 32'd1);

    // Both requesters held: PPU x MAX_BURST then CPU
    obs.delete();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_ram_sel = 1'b1; cpu_addr = 21'h00777;
    ppu_req = 1'b1; ppu_wr = 1'b1; ppu_addr = 21'h00040; ppu_wdata = 8'h11;
    repeat (40) tick();
    check("req023_count", 32'(obs.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < obs.size(); i++)
      check("req023_order", 32'(obs[i]), 32'((i % (MAX_BURST + 1)) == MAX_BURST));
    cpu_req = 1'b0; ppu_req = 1'b0;
    repeat (8) tick();

    // CPU SRAM write (also clears the burst history)
    do_req(1'b1, 1'b1, 1'b1, 21'h1ABCD, 8'h5A, "sram_wr_ack");

    // cart_ready low blocks all grants
    cart_ready = 1'b0; strobe_cnt = 0; ack_cnt = 0;
    cpu_req = 1'b1; ppu_req = 1'b1;
    repeat (100) tick();
    check("req024_strobes", 32'(strobe_cnt), 32'd0);
    check("req024_acks", 32'(ack_cnt), 32'd0);
    cart_ready = 1'b1;
    tick();
    check("req024_first", 32'({mem_chr_sel, mem_rden | mem_wren}), 32'd3);
    repeat (20) tick();
    cpu_req = 1'b0; ppu_req = 1'b0;
    repeat (8) tick();

    // Reset during WAIT of a CPU read
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_ram_sel = 1'b0; cpu_addr = 21'h00456;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rden) begin seen = 1'b1; break; end
    end
    check("req025_issue", 32'(seen), 32'd1);
    tick();
    check("req025_wait_sel", 32'(mem_prg_sel), 32'd1);
    ack_cnt = 0;
    reset_n = 1'b0;
    #1;
    check_zero("req025_rst");
    repeat (3) tick();
    check("req025_no_ack", 32'(ack_cnt), 32'd0);
    reset_n = 1'b1;
    do_req(1'b1, 1'b0, 1'b0, 21'h00456, 8'h00, "req025_after");

    // Request dropped after grant still completes
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_ram_sel = 1'b1; cpu_addr = 21'h00999;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rden) begin seen = 1'b1; break; end
    end
    cpu_req = 1'b0;
    check("viol_issue", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ack) begin seen = 1'b1; break; end
    end
    check("viol_ack", 32'(seen), 32'd1);
    repeat (3) tick();

    // Randomized traffic
    auto_en = 1'b1;
    repeat (3000) tick();
    auto_en = 1'b0;
    cpu_req = 1'b0; ppu_req = 1'b0; cart_ready = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
